a0_trace_buffer: RTL

- Sits directly downstream of the CPU top level and consumes its a0 result register output.
- Detects every change of a0 and timestamps it with a free-running cycle counter.
- Buffers each (value, stamp) pair in a small show-ahead FIFO and drains it over a valid/ready handshake to the bench or display logic.
- Lets test programs be checked by their sequence of a0 values, without sampling a0 every cycle.

---
 rtl/a0_trace_buffer.sv | 115 +++++++++++
 1 files changed

// File: rtl/a0_trace_buffer.sv
// rtl/a0_trace_buffer.sv - timestamped a0 change trace FIFO
//
// Watches the CPU a0 register and queues each change with the cycle it was
// seen on. The queued entries drain in order over a valid/ready handshake.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   en           capture enable; while low, a0 is neither compared nor tracked
//   a0           a0 value from the CPU top level
//   out_ready    consumer accepts the head entry
//   clr_overflow clears the sticky overflow flag
//   out_valid    FIFO holds at least one entry
//   out_data     a0 value of the head entry (0 when empty)
//   out_stamp    cycle stamp of the head entry (0 when empty)
//   count        number of occupied entries
//   overflow     sticky: at least one change was dropped because the FIFO was full
module a0_trace_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 8,
  parameter int STAMP_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [DATA_WIDTH-1:0]     a0,
  input  logic                      out_ready,
  input  logic                      clr_overflow,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [STAMP_WIDTH-1:0]    out_stamp,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0]  prev_a0;
  logic [STAMP_WIDTH-1:0] cycle_cnt;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [CNT_W-1:0]       count_q;
  logic                   overflow_q;

  // Storage is deliberately left out of reset; the empty-case masking on the
  // outputs keeps stale contents from ever being visible.
  logic [DATA_WIDTH-1:0]  mem_data  [DEPTH];
  logic [STAMP_WIDTH-1:0] mem_stamp [DEPTH];

  logic change_evt;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    change_evt = en && (a0 != prev_a0);
    pop        = (count_q != '0) && out_ready;
    // A pop frees the slot the write lands in, so a full FIFO can still
    // accept a push in the same cycle.
    push       = change_evt && ((count_q != DEPTH_C) || pop);
    drop       = change_evt && !push;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_a0    <= '0;
      cycle_cnt  <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + STAMP_WIDTH'(1);
      if (en) begin
        prev_a0 <= a0;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      // Set has priority over clear so a drop is never lost.
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (clr_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // The stamp stored is the counter value before this edge's increment.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr]  <= a0;
      mem_stamp[wr_ptr] <= cycle_cnt;
    end
  end

  always_comb begin
    out_valid = (count_q != '0);
    count     = count_q;
    overflow  = overflow_q;
    out_data  = out_valid ? mem_data[rd_ptr]  : '0;
    out_stamp = out_valid ? mem_stamp[rd_ptr] : '0;
  end

endmodule
